// File: rtl/jtcontra_gfx_linemix_pkg.sv
// Shared constants and helpers for the jtcontra line-buffer mixer.
// Buffer geometry, pixel type and the opacity test live here.
package jtcontra_gfx_linemix_pkg;

  localparam int BUF_AW    = 10;
  localparam int BUF_DEPTH = 1024;
  localparam int PXL_DW    = 8;
  localparam int HD_W      = 9;

  localparam logic [PXL_DW-1:0] BLANK_PXL_DEF = 8'h00;

  typedef logic [PXL_DW-1:0] pxl_t;

  typedef struct packed {
    pxl_t pxl;
    logic lyr;
    logic opaque;
  } mix_t;

  // Colour index 0 is the transparent pen; palette bits do not matter.
  function automatic logic is_opaque(input pxl_t p);
    return p[3:0] != 4'd0;
  endfunction

endpackage

// File: rtl/jtcontra_gfx_linemix_if.sv
// Renderer write bus, video timing and mixed pixel output of the line mixer.
interface jtcontra_gfx_linemix_if;
  import jtcontra_gfx_linemix_pkg::*;

  logic              pxl_cen;
  logic              LHBL;
  logic              LVBL;
  logic [HD_W-1:0]   hdump;
  logic              line;
  logic [BUF_AW-1:0] line_addr;
  pxl_t              line_din;
  logic              chr_we;
  logic              scr_we;
  pxl_t              pxl_out;
  logic              pxl_lyr;
  logic              pxl_opaque;

  modport master (
    output pxl_cen, LHBL, LVBL, hdump, line, line_addr, line_din, chr_we, scr_we,
    input  pxl_out, pxl_lyr, pxl_opaque
  );

  modport slave (
    input  pxl_cen, LHBL, LVBL, hdump, line, line_addr, line_din, chr_we, scr_we,
    output pxl_out, pxl_lyr, pxl_opaque
  );

endinterface

// File: rtl/jtframe_dual_ram.sv
// Dual-port RAM: port A write-only, port B read-first with optional write.
// On a same-address collision the port A write is the one that lands.
module jtframe_dual_ram #(
  parameter int DW = 8,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic [DW-1:0] data0,
  input  logic [AW-1:0] addr0,
  input  logic          we0,
  input  logic [DW-1:0] data1,
  input  logic [AW-1:0] addr1,
  input  logic          we1,
  output logic [DW-1:0] q1
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Port A is written last so it overrides a colliding port B write.
  always_ff @(posedge clk) begin
    q1 <= mem[addr1];
    if (we1) mem[addr1] <= data1;
    if (we0) mem[addr0] <= data0;
  end

endmodule

// File: rtl/jtcontra_gfx_linemix.sv
// Double-banked char/scroll line buffers with read-then-clear readout and a
// per-pixel priority mixer producing an 8-bit palette index.
module jtcontra_gfx_linemix
  import jtcontra_gfx_linemix_pkg::*;
#(
  parameter bit   CHR_PRIO  = 1'b1,
  parameter pxl_t BLANK_PXL = BLANK_PXL_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  jtcontra_gfx_linemix_if.slave  bus
);

  logic              active_s;
  logic [BUF_AW-1:0] portb_addr_s;
  logic              portb_we_s;
  pxl_t              chr_ram_s, scr_ram_s;
  pxl_t              hi_s, lo_s;
  mix_t              mix_s;

  logic [BUF_AW-1:0] rd_addr_q, rd_addr_d;
  logic              clr_pend_q, clr_pend_d;
  logic              vld_q, vld_d;
  pxl_t              chr_dat_q, chr_dat_d;
  pxl_t              scr_dat_q, scr_dat_d;
  pxl_t              pxl_out_q, pxl_out_d;
  logic              pxl_lyr_q, pxl_lyr_d;
  logic              pxl_opaque_q, pxl_opaque_d;

  assign active_s = bus.pxl_cen & bus.LHBL & bus.LVBL;
  // The clear cycle reuses the latched address so a line toggle cannot redirect it.
  assign portb_addr_s = clr_pend_q ? rd_addr_q : {~bus.line, bus.hdump};
  assign portb_we_s   = clr_pend_q & ~rst;

  jtframe_dual_ram #(.DW(PXL_DW), .AW(BUF_AW)) u_chr_ram (
    .clk   (clk),
    .data0 (bus.line_din),
    .addr0 (bus.line_addr),
    .we0   (bus.chr_we),
    .data1 (8'h00),
    .addr1 (portb_addr_s),
    .we1   (portb_we_s),
    .q1    (chr_ram_s)
  );

  jtframe_dual_ram #(.DW(PXL_DW), .AW(BUF_AW)) u_scr_ram (
    .clk   (clk),
    .data0 (bus.line_din),
    .addr0 (bus.line_addr),
    .we0   (bus.scr_we),
    .data1 (8'h00),
    .addr1 (portb_addr_s),
    .we1   (portb_we_s),
    .q1    (scr_ram_s)
  );

  always_comb begin
    hi_s = CHR_PRIO ? chr_dat_q : scr_dat_q;
    lo_s = CHR_PRIO ? scr_dat_q : chr_dat_q;
    if (is_opaque(hi_s)) begin
      mix_s = '{pxl: hi_s, lyr: CHR_PRIO, opaque: 1'b1};
    end else begin
      mix_s = '{pxl: lo_s, lyr: ~CHR_PRIO, opaque: is_opaque(lo_s)};
    end
  end

  always_comb begin
    rd_addr_d    = rd_addr_q;
    clr_pend_d   = active_s;
    vld_d        = vld_q;
    chr_dat_d    = chr_dat_q;
    scr_dat_d    = scr_dat_q;
    pxl_out_d    = pxl_out_q;
    pxl_lyr_d    = pxl_lyr_q;
    pxl_opaque_d = pxl_opaque_q;
    if (active_s) begin
      rd_addr_d = {~bus.line, bus.hdump};
    end
    // RAM data is only valid during the clear cycle; hold it for the mixer.
    if (clr_pend_q) begin
      chr_dat_d = chr_ram_s;
      scr_dat_d = scr_ram_s;
    end
    if (bus.pxl_cen) begin
      vld_d = active_s;
      if (vld_q) begin
        pxl_out_d    = mix_s.pxl;
        pxl_lyr_d    = mix_s.lyr;
        pxl_opaque_d = mix_s.opaque;
      end else begin
        pxl_out_d    = BLANK_PXL;
        pxl_lyr_d    = 1'b0;
        pxl_opaque_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr_q    <= '0;
      clr_pend_q   <= 1'b0;
      vld_q        <= 1'b0;
      chr_dat_q    <= 8'h00;
      scr_dat_q    <= 8'h00;
      pxl_out_q    <= BLANK_PXL;
      pxl_lyr_q    <= 1'b0;
      pxl_opaque_q <= 1'b0;
    end else begin
      rd_addr_q    <= rd_addr_d;
      clr_pend_q   <= clr_pend_d;
      vld_q        <= vld_d;
      chr_dat_q    <= chr_dat_d;
      scr_dat_q    <= scr_dat_d;
      pxl_out_q    <= pxl_out_d;
      pxl_lyr_q    <= pxl_lyr_d;
      pxl_opaque_q <= pxl_opaque_d;
    end
  end

  assign bus.pxl_out    = pxl_out_q;
  assign bus.pxl_lyr    = pxl_lyr_q;
  assign bus.pxl_opaque = pxl_opaque_q;

endmodule

// File: doc/jtcontra_gfx_linemix.md
# jtcontra_gfx_linemix

Line-buffer store and layer mixer that sits directly downstream of the 007121 tilemap renderer. Holds two double-banked line buffers, one for the scroll layer and one for the fixed character layer, written by the renderer during the previous scan line. Reads back the displayed bank at pixel rate, picks the visible layer per pixel and emits an 8-bit palette index. Each location is cleared after it is read, so pixels the renderer never writes come out transparent on the next use.

## Interface
Parameters:
- CHR_PRIO, 1: 1 = char layer over scroll layer; 0 = scroll over char.
- BLANK_PXL, 8'h00: value driven on pxl_out during blanking.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- pxl_cen  in  1  pixel clock enable; at most one pulse every 2 clk cycles.
- LHBL  in  1  horizontal blank, active low.
- LVBL  in  1  vertical blank, active low.
- hdump  in  9  current display column; valid when pxl_cen is high.
- line  in  1  bank being written by the renderer. The readout uses ~line.
- line_addr  in  10  write address {bank, column}.
- line_din  in  8  write data {pal[3:0], colour[3:0]}.
- chr_we  in  1  write strobe, char-layer buffer.
- scr_we  in  1  write strobe, scroll-layer buffer.
- pxl_out  out  8  mixed palette index.
- pxl_lyr  out  1  1 = pxl_out came from the char layer.
- pxl_opaque  out  1  1 = the selected pixel has colour[3:0] != 0.

## Operation
- Storage: two 1024x8 dual-port RAMs, one per layer. Port A is the renderer write port. Port B is read-then-clear.
- Write: on every clk with chr_we or scr_we high, line_din is written at line_addr into the matching RAM. No pxl_cen qualification.
- Readout is active only when LHBL and LVBL are both high at a pxl_cen pulse.
- Read stage (stage R), on each active pxl_cen:
  - rd_addr is latched as {~line, hdump}.
  - A read is issued on port B of both RAMs.
  - clr_pend is set.
- Clear stage (stage C), on the clk after stage R:
  - Port B writes 8'h00 to the latched rd_addr in both RAMs.
  - clr_pend is cleared.
  - The bank bit is taken from the latched rd_addr, so a line toggle between R and C does not redirect the clear.
- Mix stage (stage M), on the next pxl_cen after stage R, using registered RAM data:
  - chr_op = chr[3:0] != 0; scr_op = scr[3:0] != 0.
  - With CHR_PRIO = 1, the selection order is: if chr_op, choose chr (pxl_lyr = 1); otherwise if scr_op, choose scr (pxl_lyr = 0); otherwise choose scr with pxl_opaque = 0.
  - With CHR_PRIO = 0, the roles of chr and scr are swapped.
  - pxl_out takes the chosen byte unchanged. Transparent pixels still carry their palette bits.
- Blank: when LHBL or LVBL is low at a pxl_cen pulse:
  - stage M drives pxl_out = BLANK_PXL, pxl_lyr = 0, pxl_opaque = 0;
  - no read and no clear are issued.
- RAM contents are not cleared by rst. The first displayed line after power-up may contain stale data. This is accepted.

## Timing
- Latency: the pixel for hdump = N appears on pxl_out at the second pxl_cen after N is presented, and holds until the next pxl_cen.
- Blank tail: the first blank pxl_cen still outputs the last pipelined pixel. Blank output starts one pxl_cen later.
- Reset values: pxl_out = BLANK_PXL, pxl_lyr = 0, pxl_opaque = 0, clr_pend = 0, pipeline valid bit = 0.
- The pipeline valid bit gates stage M so that no stale pixel leaks out after reset.
- Reset mid-line: a pending clear is dropped. The location is left uncleared. This is accepted.
- Port conflicts:
  - Ports A and B address opposite banks during normal operation, so they do not collide.
  - If they do collide (same address, same cycle), the port A write wins. The RAM is write-first on port A.
- hdump wrap (511 -> 0) needs no special handling. The address is a pure concatenation.
- Bank toggle: line may toggle at any clk. Reads use ~line as sampled at the pxl_cen of stage R.

## Structure
- Constants (BLANK_PXL default, buffer depth 1024, data width 8) go in the shared jtcontra gfx package.
- Natural sub-module: jtframe_dual_ram (existing). Two instances, data width 8, address width 10.
- The read-then-clear sequencer and the mixer are local logic in this module.

## Test plan
- Char wins: write chr = 8'h35 and scr = 8'h12 at bank 0, column 100. Display bank 0 (line = 1), hdump = 100 → two pxl_cen later, pxl_out = 8'h35, pxl_lyr = 1, pxl_opaque = 1.
- Transparent char: chr = 8'h70, scr = 8'h2A at one column → pxl_out = 8'h2A, pxl_lyr = 0. With both colours 0 (chr = 8'h70, scr = 8'h50) → pxl_out = 8'h50, pxl_opaque = 0.
- Clear after read: read column 5 of bank 1, toggle line twice, read column 5 again with no new writes → pxl_out = 8'h00, pxl_opaque = 0.
- Bank isolation: during readout of bank 0, write bank 1 column 7 in the same clk as the stage-C clear of bank 0 column 7 → bank 1 data is intact on the next line.
- Blanking: drop LHBL for 3 pxl_cen → first pulse outputs the pipelined pixel, then BLANK_PXL. No port-B writes are issued while LHBL is low.
- CHR_PRIO = 0 build: chr = 8'h35, scr = 8'h12 → pxl_out = 8'h12, pxl_lyr = 0. Assert rst mid-line → all outputs go to their reset values on the next clk.
